// File: rtl/pipeline_mem_responder_pkg.sv
// Shared LC-3b types: word/mask buses plus the memory-arbiter state and client enums.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_IF_ACC   = 3'd1,
    ARB_MEM_ACC  = 3'd2,
    ARB_IF_DONE  = 3'd3,
    ARB_MEM_DONE = 3'd4,
    ARB_GAP      = 3'd5
  } lc3b_arb_state;

  typedef enum logic {
    ARB_IF  = 1'b0,
    ARB_MEM = 1'b1
  } lc3b_arb_client;

  // Winner of an IDLE-cycle arbitration; only meaningful when a request is present.
  function automatic lc3b_arb_client arb_pick(input logic if_req, input logic mem_req,
                                              input lc3b_arb_client last, input logic fair);
    if (mem_req && (!if_req || !fair || last == ARB_IF))
      return ARB_MEM;
    return ARB_IF;
  endfunction

endpackage

// File: rtl/pipeline_mem_responder_if.sv
// Bus bundle between the pipeline's two initiators, the responder and the backing memory.
interface pipeline_mem_responder_if;
  import lc3b_types::*;

  // Clients hold a request (memread/memwrite) steady until their one-cycle resp pulse;
  // the responder holds a pmem strobe until the one-cycle pmem_resp, rdata valid with resp.
  lc3b_word      if_memaddr;
  logic          if_memread;
  lc3b_mem_wmask if_mem_byte_enable;
  logic          if_mem_resp;
  lc3b_word      if_mem_rdata;

  lc3b_word      mem_memaddr;
  logic          mem_memread;
  logic          mem_memwrite;
  lc3b_mem_wmask mem_mem_byte_enable;
  lc3b_word      mem_mem_wdata;
  logic          mem_mem_resp;
  lc3b_word      mem_mem_rdata;

  lc3b_word      pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_wdata;
  logic          pmem_resp;
  lc3b_word      pmem_rdata;

  modport slave (
    input  if_memaddr, if_memread, if_mem_byte_enable,
    output if_mem_resp, if_mem_rdata,
    input  mem_memaddr, mem_memread, mem_memwrite, mem_mem_byte_enable, mem_mem_wdata,
    output mem_mem_resp, mem_mem_rdata,
    output pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output if_memaddr, if_memread, if_mem_byte_enable,
    input  if_mem_resp, if_mem_rdata,
    output mem_memaddr, mem_memread, mem_memwrite, mem_mem_byte_enable, mem_mem_wdata,
    input  mem_mem_resp, mem_mem_rdata,
    input  pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/pipeline_mem_responder.sv
// Arbitrates the IF and MEM initiators onto one physical memory port and returns a
// one-cycle resp pulse with read data to whichever client was served.
module pipeline_mem_responder
  import lc3b_types::*;
#(
  parameter bit FAIR   = 1'b1,
  parameter bit IF_GAP = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_mem_responder_if.slave  bus,
  output logic                     err_rw,
  output lc3b_arb_state            dbg_state
);

  lc3b_arb_state  state;
  lc3b_arb_client last_grant;

  lc3b_word       addr_q;
  lc3b_mem_wmask  be_q;
  lc3b_word       wdata_q;
  logic           pmem_read_q;
  logic           pmem_write_q;
  logic           if_resp_q;
  logic           mem_resp_q;
  lc3b_word       if_rdata_q;
  lc3b_word       mem_rdata_q;
  logic           err_q;

  logic           if_req;
  logic           mem_req;
  lc3b_arb_client winner;

  always_comb begin
    if_req  = bus.if_memread;
    mem_req = bus.mem_memread | bus.mem_memwrite;
    winner  = arb_pick(if_req, mem_req, last_grant, FAIR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      last_grant   <= ARB_IF;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      if_resp_q    <= 1'b0;
      mem_resp_q   <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_req || mem_req) begin
            if (winner == ARB_MEM) begin
              addr_q       <= bus.mem_memaddr;
              be_q         <= bus.mem_mem_byte_enable;
              wdata_q      <= bus.mem_mem_wdata;
              // Read+write together is resolved as a write and flagged.
              pmem_write_q <= bus.mem_memwrite;
              pmem_read_q  <= ~bus.mem_memwrite;
              if (bus.mem_memread && bus.mem_memwrite)
                err_q <= 1'b1;
              last_grant   <= ARB_MEM;
              state        <= ARB_MEM_ACC;
            end else begin
              addr_q       <= bus.if_memaddr;
              be_q         <= bus.if_mem_byte_enable;
              pmem_write_q <= 1'b0;
              pmem_read_q  <= 1'b1;
              last_grant   <= ARB_IF;
              state        <= ARB_IF_ACC;
            end
          end
        end

        ARB_IF_ACC: begin
          if (bus.pmem_resp) begin
            if (pmem_read_q)
              if_rdata_q <= bus.pmem_rdata;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            if_resp_q    <= 1'b1;
            state        <= ARB_IF_DONE;
          end
        end

        ARB_MEM_ACC: begin
          if (bus.mem_memread && bus.mem_memwrite)
            err_q <= 1'b1;
          if (bus.pmem_resp) begin
            if (pmem_read_q)
              mem_rdata_q <= bus.pmem_rdata;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            mem_resp_q   <= 1'b1;
            state        <= ARB_MEM_DONE;
          end
        end

        ARB_IF_DONE: begin
          if_resp_q <= 1'b0;
          state     <= IF_GAP ? ARB_GAP : ARB_IDLE;
        end

        ARB_MEM_DONE: begin
          mem_resp_q <= 1'b0;
          state      <= ARB_IDLE;
        end

        ARB_GAP: state <= ARB_IDLE;

        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Every bus-facing output comes straight from a register.
  assign bus.pmem_address     = addr_q;
  assign bus.pmem_byte_enable = be_q;
  assign bus.pmem_wdata       = wdata_q;
  assign bus.pmem_read        = pmem_read_q;
  assign bus.pmem_write       = pmem_write_q;
  assign bus.if_mem_resp      = if_resp_q;
  assign bus.if_mem_rdata     = if_rdata_q;
  assign bus.mem_mem_resp     = mem_resp_q;
  assign bus.mem_mem_rdata    = mem_rdata_q;
  assign err_rw               = err_q;
  assign dbg_state            = state;

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Directed bench for pipeline_mem_responder: scoreboard of expected responses plus
// per-access strobe/address checks, with a FAIR=0 instance for the tie policy.
module tb_pipeline_mem_responder;
  import lc3b_types::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [16:0] exp_q[$];
  logic [16:0] exp1_q[$];

  pipeline_mem_responder_if b0 ();
  pipeline_mem_responder_if b1 ();
  logic          err0, err1;
  lc3b_arb_state st0, st1;

  pipeline_mem_responder #(.FAIR(1'b1), .IF_GAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .err_rw(err0), .dbg_state(st0));
  pipeline_mem_responder #(.FAIR(1'b0), .IF_GAP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .err_rw(err1), .dbg_state(st1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // backing memory models
  int       lat0 = 1;
  int       m0_cnt = 0;
  logic     m0_resp = 1'b0;
  lc3b_word rd_val0 = '0;
  logic     model_en = 1'b1;
  logic     man_resp = 1'b0;
  lc3b_word man_rdata = '0;
  logic     m1_resp = 1'b0;

  always @(posedge clk) begin
    #1;
    if ((b0.pmem_read || b0.pmem_write) && !m0_resp) begin
      if (m0_cnt >= lat0 - 1) begin
        m0_resp = 1'b1;
        m0_cnt  = 0;
      end else begin
        m0_cnt++;
      end
    end else begin
      m0_resp = 1'b0;
      m0_cnt  = 0;
    end
  end
  assign b0.pmem_resp  = model_en ? m0_resp : man_resp;
  assign b0.pmem_rdata = model_en ? rd_val0 : man_rdata;

  always @(posedge clk) begin
    #1;
    m1_resp = (b1.pmem_read || b1.pmem_write) && !m1_resp;
  end
  assign b1.pmem_resp  = m1_resp;
  assign b1.pmem_rdata = 16'h7777;

  // scoreboard monitors: entry = {served_by_mem, rdata}
  always @(negedge clk) begin
    logic [16:0] act, exp;
    if (b0.if_mem_resp || b0.mem_mem_resp) begin
      act = {b0.mem_mem_resp, b0.mem_mem_resp ? b0.mem_mem_rdata : b0.if_mem_rdata};
      checks++;
      if (b0.if_mem_resp && b0.mem_mem_resp) begin
        failures++;
        $display("FAIL resp0_both act=both_resp required=one_resp");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp0_unexpected act=%h required=no_resp", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL resp0 act=%h required=%h", act, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] act, exp;
    if (b1.if_mem_resp || b1.mem_mem_resp) begin
      act = {b1.mem_mem_resp, b1.mem_mem_resp ? b1.mem_mem_rdata : b1.if_mem_rdata};
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL resp1_unexpected act=%h required=no_resp", act);
      end else begin
        exp = exp1_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL resp1 act=%h required=%h", act, exp);
        end
      end
    end
  end

  // driver / check tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    b0.if_memread   = 1'b0;
    b0.mem_memread  = 1'b0;
    b0.mem_memwrite = 1'b0;
  endtask

  // Waits for a resp on dut0, counting strobe cycles that match the watched request.
  task automatic run_access(input string name, input lc3b_word a, input lc3b_word wd,
                            input logic [1:0] be, output int lat_c, output int rd_c,
                            output int wr_c, output int oth_c,
                            output logic saw_if, output logic saw_mem);
    lat_c = 0; rd_c = 0; wr_c = 0; oth_c = 0; saw_if = 1'b0; saw_mem = 1'b0;
    do begin
      @(negedge clk);
      lat_c++;
      if (b0.pmem_read) begin
        if (b0.pmem_address == a) rd_c++;
        else oth_c++;
      end
      if (b0.pmem_write) begin
        if (b0.pmem_address == a && b0.pmem_wdata == wd && b0.pmem_byte_enable == be) wr_c++;
        else oth_c++;
      end
      if (b0.if_mem_resp)  saw_if  = 1'b1;
      if (b0.mem_mem_resp) saw_mem = 1'b1;
    end while (!saw_if && !saw_mem && lat_c < 60);
    if (!saw_if && !saw_mem) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout act=no_resp required=resp", name);
    end
  endtask

  initial begin
    int lat_c, rd_c, wr_c, oth_c, n, resps, if_resps;
    logic saw_if, saw_mem;

    rst = 1'b1;
    drop_all();
    b0.if_memaddr = '0; b0.if_mem_byte_enable = '0;
    b0.mem_memaddr = '0; b0.mem_mem_byte_enable = '0; b0.mem_mem_wdata = '0;
    b1.if_memaddr = 16'h0010; b1.if_memread = 1'b0; b1.if_mem_byte_enable = 2'b11;
    b1.mem_memaddr = 16'h0020; b1.mem_memread = 1'b0; b1.mem_memwrite = 1'b0;
    b1.mem_mem_byte_enable = 2'b11; b1.mem_mem_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", st0, ARB_IDLE);
    check("rst_strobes", {b0.pmem_read, b0.pmem_write}, 0);
    check("rst_resps", {b0.if_mem_resp, b0.mem_mem_resp}, 0);
    check("rst_rdata", {b0.if_mem_rdata, b0.mem_mem_rdata}, 0);
    check("rst_pmem_bus", {b0.pmem_address, b0.pmem_wdata}, 0);
    check("rst_be", b0.pmem_byte_enable, 0);
    check("rst_err", err0, 0);
    rst = 1'b0;

    // IF-only read, 3-cycle memory
    lat0 = 3; rd_val0 = 16'h1234;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 16'h1234});
    b0.if_memaddr = 16'h0040; b0.if_mem_byte_enable = 2'b11; b0.if_memread = 1'b1;
    run_access("if_read", 16'h0040, 16'h0000, 2'b11, lat_c, rd_c, wr_c, oth_c, saw_if, saw_mem);
    drop_all();
    check("if_read_latency", lat_c, 5);
    check("if_read_strobe_cycles", rd_c, 3);
    check("if_read_other_strobes", wr_c + oth_c, 0);
    check("if_read_no_mem_resp", saw_mem, 0);
    repeat (2) @(negedge clk);
    check("if_rdata_held", b0.if_mem_rdata, 16'h1234);
    check("if_read_strobe_low", b0.pmem_read, 0);

    // MEM write
    lat0 = 2;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 16'h0000});
    b0.mem_memaddr = 16'h0100; b0.mem_mem_wdata = 16'hBEEF;
    b0.mem_mem_byte_enable = 2'b01; b0.mem_memwrite = 1'b1;
    run_access("mem_write", 16'h0100, 16'hBEEF, 2'b01, lat_c, rd_c, wr_c, oth_c, saw_if, saw_mem);
    drop_all();
    check("mem_write_latency", lat_c, 4);
    check("mem_write_strobe_cycles", wr_c, 2);
    check("mem_write_other_strobes", rd_c + oth_c, 0);
    check("mem_write_no_if_resp", saw_if, 0);
    check("mem_write_err", err0, 0);

    // MEM read; client address changes mid-access
    lat0 = 4; rd_val0 = 16'hCAFE;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 16'hCAFE});
    b0.mem_memaddr = 16'h0100; b0.mem_mem_byte_enable = 2'b11; b0.mem_memread = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("addr_hold_first", {b0.pmem_read, b0.pmem_address}, {1'b1, 16'h0100});
    b0.mem_memaddr = 16'h0200;
    run_access("addr_hold", 16'h0100, 16'h0000, 2'b11, lat_c, rd_c, wr_c, oth_c, saw_if, saw_mem);
    drop_all();
    check("addr_hold_cycles", rd_c, 3);
    check("addr_hold_other", wr_c + oth_c, 0);
    check("addr_hold_after", b0.pmem_address, 16'h0100);
    check("mem_read_if_rdata_kept", b0.if_mem_rdata, 16'h1234);

    // reset during IF_ACC, then a stray pmem_resp
    model_en = 1'b0;
    @(posedge clk); #1;
    b0.if_memaddr = 16'h0300; b0.if_memread = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_strobe_before", b0.pmem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_strobe", b0.pmem_read, 0);
    check("midrst_state", st0, ARB_IDLE);
    check("midrst_no_resp", b0.if_mem_resp, 0);
    rst = 1'b0;
    drop_all();
    @(posedge clk); #1;
    man_resp = 1'b1; man_rdata = 16'hDEAD;
    @(posedge clk); #1;
    man_resp = 1'b0;
    @(negedge clk);
    check("late_resp_state", st0, ARB_IDLE);
    check("late_resp_rdata", {b0.if_mem_rdata, b0.mem_mem_rdata}, 0);
    model_en = 1'b1;

    // tie, FAIR=1: MEM, IF, MEM, IF
    lat0 = 1; rd_val0 = 16'h5555;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 16'h5555});
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b1, 16'h5555});
    exp_q.push_back({1'b0, 16'h5555});
    b0.if_memaddr = 16'h0010; b0.if_memread = 1'b1;
    b0.mem_memaddr = 16'h0020; b0.mem_memread = 1'b1;
    resps = 0; n = 0;
    while (resps < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (b0.if_mem_resp || b0.mem_mem_resp) resps++;
    end
    drop_all();
    check("tie_fair_resps", resps, 4);

    // read+write together: resolved as write, sticky error
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 16'h5555});
    b0.mem_memaddr = 16'h0400; b0.mem_mem_wdata = 16'h1111; b0.mem_mem_byte_enable = 2'b11;
    b0.mem_memread = 1'b1; b0.mem_memwrite = 1'b1;
    run_access("rw_both", 16'h0400, 16'h1111, 2'b11, lat_c, rd_c, wr_c, oth_c, saw_if, saw_mem);
    drop_all();
    check("rw_both_write_cycles", wr_c, 1);
    check("rw_both_no_read", rd_c + oth_c, 0);
    check("rw_both_err", err0, 1);
    repeat (4) @(negedge clk);
    check("err_sticky", err0, 1);

    // tie, FAIR=0: MEM every time
    @(posedge clk); #1;
    exp1_q.push_back({1'b1, 16'h7777});
    exp1_q.push_back({1'b1, 16'h7777});
    exp1_q.push_back({1'b1, 16'h7777});
    b1.if_memread = 1'b1; b1.mem_memread = 1'b1;
    resps = 0; if_resps = 0; n = 0;
    while (resps < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (b1.mem_mem_resp) resps++;
      if (b1.if_mem_resp) if_resps++;
    end
    b1.if_memread = 1'b0; b1.mem_memread = 1'b0;
    check("tie_mem_wins_resps", resps, 3);
    check("tie_mem_wins_no_if", if_resps, 0);

    // reset clears the sticky error
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("err_cleared", err0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard0_drained", exp_q.size(), 0);
    check("scoreboard1_drained", exp1_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_responder.md
Name: pipeline_mem_responder

Overview:
- Responder side of the pipeline's two memory initiator ports: IF (read-only instruction fetch) and MEM (data load/store).
- Arbitrates both clients onto one physical memory port (pmem_*) and returns a one-cycle resp pulse with read data to the winner.
- Sits between the pipeline datapath and the backing memory or cache.
- Owns all request latching, so the pipeline may hold its request lines steady until resp.

Parameters:
FAIR, 1, 1 = alternate grants on simultaneous requests; 0 = MEM always wins ties
IF_GAP, 0, 1 = insert one idle cycle after each IF response before IF may be re-granted (debug); 0 = none

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
if_memaddr  in  16  IF word address
if_memread  in  1  IF read request, held until if_mem_resp
if_mem_byte_enable  in  2  IF byte enables (passed through)
if_mem_resp  out  1  one-cycle IF completion pulse
if_mem_rdata  out  16  IF read data, valid with resp and held afterwards
mem_memaddr  in  16  MEM address
mem_memread  in  1  MEM read request
mem_memwrite  in  1  MEM write request
mem_mem_byte_enable  in  2  MEM byte enables
mem_mem_wdata  in  16  MEM write data
mem_mem_resp  out  1  one-cycle MEM completion pulse
mem_mem_rdata  out  16  MEM read data, valid with resp and held afterwards
pmem_address  out  16  physical memory address
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_byte_enable  out  2  physical byte enables
pmem_wdata  out  16  physical write data
pmem_resp  in  1  physical completion pulse
pmem_rdata  in  16  physical read data, valid with pmem_resp
err_rw  out  1  sticky flag; set when mem_memread and mem_memwrite are both high while granted

Behaviour:
- Reset values:
  - state IDLE; last_grant = IF, so MEM wins the first tie.
  - All resp outputs and pmem_read/pmem_write are 0.
  - Both rdata registers, pmem_address, pmem_wdata and err_rw are 0; pmem_byte_enable is 2'b00.
- States: IDLE, IF_ACC, MEM_ACC, IF_DONE, MEM_DONE, GAP.
- IDLE:
  - MEM request = mem_memread | mem_memwrite; IF request = if_memread.
  - Only one request present: grant it.
  - Both present and FAIR=1: grant the client that is not last_grant. FAIR=0: grant MEM.
  - On grant, latch address, byte enables, wdata and the rw kind into request registers, update last_grant, and go to xx_ACC.
  - A MEM request with both read and write high is treated as a write and sets err_rw.
- xx_ACC:
  - pmem_read or pmem_write is driven from the latched rw bit; address, be and wdata come from the latched registers, so client changes have no effect.
  - Stay until pmem_resp. On pmem_resp, capture pmem_rdata into that client's rdata register (reads only; writes leave it unchanged) and go to xx_DONE.
  - Strobes are registered outputs: they rise the cycle after grant and fall the cycle after pmem_resp.
- xx_DONE:
  - Assert that client's resp for exactly one cycle, with no pmem strobe.
  - Next state is IDLE, or GAP if IF_DONE and IF_GAP=1.
- GAP: one cycle with no grants, then IDLE.
- Latency:
  - From request seen in IDLE to resp is 1 (grant) + N (pmem cycles up to and including pmem_resp) + 1 (DONE).
  - Minimum spacing between consecutive grants is one IDLE cycle.
- Client drops its request during ACC: the access still completes and resp still pulses.
- A pmem_resp outside the ACC states is ignored.
- Reset mid-access:
  - The next cycle is IDLE with strobes low; the outstanding pmem response is abandoned.
  - The backing memory must tolerate an abandoned request.
- if_mem_rdata and mem_mem_rdata each hold their last captured value until that client's next read completes.

Decomposition:
- Add a state enum lc3b_arb_state and a grant enum lc3b_arb_client {ARB_IF, ARB_MEM} to the lc3b_types package.
- Reuse the package's lc3b_word for all 16-bit buses.
- Single module; no sub-module is warranted (FSM plus request and rdata registers).

Test Plan:
- IF-only read: if_memaddr=0x0040, pmem returns 0x1234 after 3 cycles -> pmem_read high 3 cycles at address 0x0040, if_mem_resp pulses one cycle later with if_mem_rdata=0x1234; mem_mem_resp stays 0.
- MEM write: addr 0x0100, wdata 0xBEEF, be 2'b01 -> pmem_write with those values; mem_mem_resp pulses; mem_mem_rdata unchanged; err_rw=0.
- Tie with FAIR=1, both clients requesting continuously: MEM is granted first, then IF, then MEM (alternating); with FAIR=0 MEM is granted every time.
- Client changes mem_memaddr from 0x0100 to 0x0200 during MEM_ACC -> pmem_address stays 0x0100 until the access completes.
- rst asserted during IF_ACC -> next cycle pmem_read=0, state IDLE, no if_mem_resp; a late pmem_resp is ignored.
- mem_memread=mem_memwrite=1 -> write performed, err_rw=1 and stays 1 until rst.
